// File: rtl/clk_tick_pkg.sv
// Shared definitions for the multi-rate tick generator: the 2-bit mode
// encoding and a helper that says which modes advance the seconds counter.
package clk_tick_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_STEP   = 2'b11;

  // NORMAL and FAST run the sub-second counter; HOLD and STEP freeze it.
  function automatic logic mode_runs_seconds(input logic [1:0] m);
    logic run;
    case (m)
      MODE_NORMAL: run = 1'b1;
      MODE_FAST:   run = 1'b1;
      MODE_HOLD:   run = 1'b0;
      MODE_STEP:   run = 1'b0;
      default:     run = 1'b0;
    endcase
    return run;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-MODULUS counter that advances when 'advance' is high and raises a
// one-cycle terminal-count pulse on the advance that wraps it back to zero.
module tick_prescaler #(
  parameter int unsigned MODULUS = 10
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic tc
);

  localparam int unsigned     CNT_W    = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Clear suppresses the pulse in the same cycle so it always wins.
  assign tc = advance & ~clear & (count_r == CNT_LAST);

  // Wrapping count; frozen whenever advance is low.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (clear) begin
      count_r <= CNT_ZERO;
    end else if (advance) begin
      count_r <= (count_r == CNT_LAST) ? CNT_ZERO : (count_r + CNT_ONE);
    end
  end

endmodule

// File: rtl/multi_rate_tick_gen.sv
// Multi-rate tick generator: display-scan tick, blink square wave and a
// seconds tick/square wave whose rate depends on the selected mode.
module multi_rate_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BLINK_HZ    = 2,
  parameter int unsigned FAST_FACTOR = 100
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] mode,
  input  logic       step,
  output logic       tick_scan,
  output logic       tick_1hz,
  output logic       clk_1hz,
  output logic       blink
);

  // The divisions below are exact only when CLK_HZ is a multiple of SCAN_HZ
  // and SCAN_HZ is a multiple of both 2*BLINK_HZ and FAST_FACTOR.
  localparam int unsigned N_SCAN      = CLK_HZ / SCAN_HZ;
  localparam int unsigned N_BLINK     = SCAN_HZ / (2 * BLINK_HZ);
  localparam int unsigned WRAP_NORMAL = SCAN_HZ;
  localparam int unsigned WRAP_FAST   = SCAN_HZ / FAST_FACTOR;
  localparam int unsigned SUB_W       = (WRAP_NORMAL > 1) ? $clog2(WRAP_NORMAL) : 1;

  localparam logic [SUB_W-1:0] SUB_ZERO    = {SUB_W{1'b0}};
  localparam logic [SUB_W-1:0] SUB_ONE     = SUB_W'(1);
  localparam logic [SUB_W-1:0] LAST_NORMAL = SUB_W'(WRAP_NORMAL - 1);
  localparam logic [SUB_W-1:0] LAST_FAST   = SUB_W'(WRAP_FAST - 1);
  localparam logic [SUB_W-1:0] HALF_NORMAL = SUB_W'(WRAP_NORMAL / 2);
  localparam logic [SUB_W-1:0] HALF_FAST   = SUB_W'(WRAP_FAST / 2);

  logic             tick_scan_s;
  logic             blink_tc_s;
  logic             run_sec_s;
  logic             mode_chg_s;
  logic             sec_tc_s;
  logic             step_rise_s;
  logic             tick_1hz_s;
  logic [SUB_W-1:0] wrap_last_s;
  logic [SUB_W-1:0] half_s;

  logic [SUB_W-1:0] sub_cnt_r;
  logic [1:0]       mode_d_r;
  logic             step_d_r;
  logic             step_tick_r;
  logic             clk_1hz_r;
  logic             blink_r;

  // Scan divider runs on every enabled clock regardless of mode.
  tick_prescaler #(
    .MODULUS (N_SCAN)
  ) u_scan_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (clear),
    .advance    (enable),
    .tc         (tick_scan_s)
  );

  // Blink divider counts scan ticks; its terminal count toggles blink.
  tick_prescaler #(
    .MODULUS (N_BLINK)
  ) u_blink_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (clear),
    .advance    (tick_scan_s),
    .tc         (blink_tc_s)
  );

  assign run_sec_s   = mode_runs_seconds(mode);
  assign mode_chg_s  = (mode != mode_d_r);
  assign sec_tc_s    = run_sec_s & tick_scan_s & (sub_cnt_r == wrap_last_s);
  assign step_rise_s = step & ~step_d_r;

  // Select the seconds modulus and the clk_1hz half-period threshold for the mode.
  always_comb begin
    wrap_last_s = LAST_NORMAL;
    half_s      = HALF_NORMAL;
    case (mode)
      MODE_FAST: begin
        wrap_last_s = LAST_FAST;
        half_s      = HALF_FAST;
      end
      default: begin
        wrap_last_s = LAST_NORMAL;
        half_s      = HALF_NORMAL;
      end
    endcase
  end

  // Seconds pulse: terminal count in NORMAL/FAST, pending step edge in STEP;
  // suppressed by clear, disable, or a mode change this cycle.
  always_comb begin
    tick_1hz_s = 1'b0;
    if (clear || !enable || mode_chg_s) begin
      tick_1hz_s = 1'b0;
    end else if (mode == MODE_STEP) begin
      tick_1hz_s = step_tick_r;
    end else begin
      tick_1hz_s = sec_tc_s;
    end
  end

  // Remember the mode seen at the previous edge to detect mode changes.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      mode_d_r <= MODE_NORMAL;
    end else begin
      mode_d_r <= mode;
    end
  end

  // Sub-second counter: restarts on clear or mode change, advances on scan ticks.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sub_cnt_r <= SUB_ZERO;
    end else if (clear || mode_chg_s) begin
      sub_cnt_r <= SUB_ZERO;
    end else if (enable && run_sec_s && tick_scan_s) begin
      sub_cnt_r <= (sub_cnt_r == wrap_last_s) ? SUB_ZERO : (sub_cnt_r + SUB_ONE);
    end
  end

  // Step edge detector and the one-cycle pending step tick it produces.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      step_d_r    <= 1'b0;
      step_tick_r <= 1'b0;
    end else if (clear) begin
      step_d_r    <= 1'b0;
      step_tick_r <= 1'b0;
    end else begin
      step_d_r    <= step;
      step_tick_r <= enable & (mode == MODE_STEP) & step_rise_s;
    end
  end

  // clk_1hz follows the counter one cycle late; holds when not running.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      clk_1hz_r <= 1'b0;
    end else if (clear) begin
      clk_1hz_r <= 1'b0;
    end else if (enable && run_sec_s) begin
      clk_1hz_r <= (sub_cnt_r >= half_s);
    end
  end

  // Blink square wave toggles at each blink-divider terminal count.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      blink_r <= 1'b0;
    end else if (clear) begin
      blink_r <= 1'b0;
    end else if (blink_tc_s) begin
      blink_r <= ~blink_r;
    end
  end

  assign tick_scan = tick_scan_s;
  assign tick_1hz  = tick_1hz_s;
  assign clk_1hz   = clk_1hz_r;
  assign blink     = blink_r;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Scoreboard bench for multi_rate_tick_gen at CLK_HZ=1000, SCAN_HZ=100,
// BLINK_HZ=2, FAST_FACTOR=10. Pulses are stamped with the edge that samples
// them (cyc+1 at the negedge); level changes with the edge that made them.
module tb_multi_rate_tick_gen;
  import clk_tick_pkg::*;

  typedef struct {
    int   e;
    logic v;
  } lvl_ev_t;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b1;
  logic       clear      = 1'b0;
  logic [1:0] mode       = MODE_NORMAL;
  logic       step       = 1'b0;
  logic       tick_scan;
  logic       tick_1hz;
  logic       clk_1hz;
  logic       blink;

  int  cyc    = 0;
  int  t0     = 0;
  int  t1     = 0;
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  scan_chk  = 1'b0;
  bit  mon_clk   = 1'b0;
  bit  mon_blink = 1'b0;
  logic prev_clk   = 1'b0;
  logic prev_blink = 1'b0;
  lvl_ev_t ev;

  int      q_tick1[$];
  int      q_scan[$];
  lvl_ev_t q_clk[$];
  lvl_ev_t q_blink[$];

  multi_rate_tick_gen #(
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .BLINK_HZ    (2),
    .FAST_FACTOR (10)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .mode       (mode),
    .step       (step),
    .tick_scan  (tick_scan),
    .tick_1hz   (tick_1hz),
    .clk_1hz    (clk_1hz),
    .blink      (blink)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk_100MHz) begin
    if (reset) begin
      prev_clk   = 1'b0;
      prev_blink = 1'b0;
    end else begin
      if (tick_1hz !== 1'b0) begin
        if (q_tick1.size() > 0) check_int("tick_1hz edge", cyc + 1, q_tick1.pop_front());
        else check_int("tick_1hz unexpected at edge", cyc + 1, -1);
      end
      if (scan_chk && tick_scan !== 1'b0) begin
        if (q_scan.size() > 0) check_int("tick_scan edge", cyc + 1, q_scan.pop_front());
        else check_int("tick_scan unexpected at edge", cyc + 1, -1);
      end
      if (clk_1hz !== prev_clk) begin
        if (mon_clk) begin
          if (q_clk.size() > 0) begin
            ev = q_clk.pop_front();
            check_int("clk_1hz change edge", cyc, ev.e);
            check_int("clk_1hz level", int'(clk_1hz), int'(ev.v));
          end else begin
            check_int("clk_1hz unexpected change at edge", cyc, -1);
          end
        end
        prev_clk = clk_1hz;
      end
      if (blink !== prev_blink) begin
        if (mon_blink) begin
          if (q_blink.size() > 0) begin
            ev = q_blink.pop_front();
            check_int("blink change edge", cyc, ev.e);
            check_int("blink level", int'(blink), int'(ev.v));
          end else begin
            check_int("blink unexpected change at edge", cyc, -1);
          end
        end
        prev_blink = blink;
      end
    end
  end

  task automatic run_to(input int e);
    while (cyc < e) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  // Assert reset between edges, check outputs drop at once, release mid-cycle.
  task automatic do_reset(input logic [1:0] m);
    #2;
    reset  = 1'b1;
    mode   = m;
    clear  = 1'b0;
    enable = 1'b1;
    #1;
    check_int("reset tick_scan", int'(tick_scan), 0);
    check_int("reset tick_1hz", int'(tick_1hz), 0);
    check_int("reset clk_1hz", int'(clk_1hz), 0);
    check_int("reset blink", int'(blink), 0);
    repeat (2) @(negedge clk_100MHz);
    #1;
    reset = 1'b0;
    t0    = cyc;
  endtask

  task automatic drain(input string name);
    check_int({name, " tick_1hz events missing"}, q_tick1.size(), 0);
    check_int({name, " tick_scan events missing"}, q_scan.size(), 0);
    check_int({name, " clk_1hz changes missing"}, q_clk.size(), 0);
    check_int({name, " blink changes missing"}, q_blink.size(), 0);
    q_tick1.delete();
    q_scan.delete();
    q_clk.delete();
    q_blink.delete();
    scan_chk  = 1'b0;
    mon_clk   = 1'b0;
    mon_blink = 1'b0;
  endtask

  initial begin
    // NORMAL from reset: scan ticks, first seconds tick, clk_1hz and blink.
    do_reset(MODE_NORMAL);
    scan_chk = 1'b1; mon_clk = 1'b1; mon_blink = 1'b1;
    q_scan.push_back(t0 + 10); q_scan.push_back(t0 + 20); q_scan.push_back(t0 + 30);
    q_tick1.push_back(t0 + 1000);
    q_clk.push_back('{t0 + 501, 1'b1}); q_clk.push_back('{t0 + 1001, 1'b0});
    q_blink.push_back('{t0 + 250, 1'b1}); q_blink.push_back('{t0 + 500, 1'b0});
    q_blink.push_back('{t0 + 750, 1'b1}); q_blink.push_back('{t0 + 1000, 1'b0});
    run_to(t0 + 35);
    scan_chk = 1'b0;
    run_to(t0 + 1005);
    drain("normal");

    // FAST from reset: seconds every 100 cycles, blink unchanged.
    do_reset(MODE_FAST);
    mon_clk = 1'b1; mon_blink = 1'b1;
    q_tick1.push_back(t0 + 100); q_tick1.push_back(t0 + 200);
    q_clk.push_back('{t0 + 51, 1'b1});  q_clk.push_back('{t0 + 101, 1'b0});
    q_clk.push_back('{t0 + 151, 1'b1}); q_clk.push_back('{t0 + 201, 1'b0});
    q_clk.push_back('{t0 + 251, 1'b1});
    q_blink.push_back('{t0 + 250, 1'b1});
    run_to(t0 + 255);
    drain("fast");

    // NORMAL 400, HOLD 300, NORMAL again: counter restarts at the change.
    do_reset(MODE_NORMAL);
    mon_clk = 1'b1; mon_blink = 1'b1;
    q_tick1.push_back(t0 + 1700);
    q_clk.push_back('{t0 + 1201, 1'b1}); q_clk.push_back('{t0 + 1701, 1'b0});
    for (int k = 1; k <= 6; k++) q_blink.push_back('{t0 + 250 * k, logic'(k % 2)});
    run_to(t0 + 400);
    mode = MODE_HOLD;
    scan_chk = 1'b1;
    q_scan.push_back(t0 + 410); q_scan.push_back(t0 + 420); q_scan.push_back(t0 + 430);
    run_to(t0 + 435);
    scan_chk = 1'b0;
    run_to(t0 + 700);
    mode = MODE_NORMAL;
    run_to(t0 + 1705);
    drain("hold");

    // STEP: two held-high step pulses give exactly two ticks.
    do_reset(MODE_STEP);
    mon_clk = 1'b1;
    q_tick1.push_back(t0 + 22); q_tick1.push_back(t0 + 102);
    run_to(t0 + 20);  step = 1'b1;
    run_to(t0 + 70);  step = 1'b0;
    run_to(t0 + 100); step = 1'b1;
    run_to(t0 + 150); step = 1'b0;
    run_to(t0 + 180); step = 1'b1;
    run_to(t0 + 181);
    check_int("step tick pending before reset", int'(tick_1hz), 1);
    drain("step");
    step = 1'b0;
    do_reset(MODE_STEP);
    run_to(t0 + 60);
    drain("step abort");

    // Clear on a terminal count, then a 37-cycle enable gap.
    do_reset(MODE_FAST);
    q_tick1.push_back(t0 + 100);
    run_to(t0 + 199);
    check_int("tick_1hz at terminal count", int'(tick_1hz), 1);
    check_int("clk_1hz before clear", int'(clk_1hz), 1);
    clear = 1'b1;
    #1;
    check_int("clear masks tick_1hz", int'(tick_1hz), 0);
    check_int("clear masks tick_scan", int'(tick_scan), 0);
    run_to(t0 + 200);
    clear = 1'b0;
    check_int("after clear clk_1hz", int'(clk_1hz), 0);
    check_int("after clear blink", int'(blink), 0);
    check_int("after clear tick_1hz", int'(tick_1hz), 0);
    t1 = t0 + 200;
    q_tick1.push_back(t1 + 137); q_tick1.push_back(t1 + 237);
    run_to(t1 + 29);
    check_int("tick_scan before disable", int'(tick_scan), 1);
    enable = 1'b0;
    #1;
    check_int("disable masks tick_scan", int'(tick_scan), 0);
    run_to(t1 + 66);
    enable = 1'b1;
    run_to(t1 + 240);
    drain("clear/enable");

    // Asynchronous reset mid-count; timing restarts from release.
    do_reset(MODE_NORMAL);
    run_to(t0 + 260);
    check_int("blink high before reset", int'(blink), 1);
    do_reset(MODE_NORMAL);
    scan_chk = 1'b1;
    q_scan.push_back(t0 + 10); q_scan.push_back(t0 + 20);
    q_tick1.push_back(t0 + 1000);
    run_to(t0 + 25);
    scan_chk = 1'b0;
    run_to(t0 + 1002);
    drain("async reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at edge %0d, expected finish before it", cyc);
    $fatal(1);
  end

endmodule
